// File: rtl/read_issuer.sv
// read_issuer: takes one- or two-word CPU read requests, issues the word
// reads on the memory bus and forwards in-order returns to the read buffer.
// A flush abandons the request and counts the reads still in flight so that
// their stale returns are swallowed instead of reaching the buffer.
module read_issuer #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_len,
    output logic                  bus_read_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_read_data,
    input  logic                  bus_read_data_valid,
    output logic                  buf_clear,
    output logic [DATA_WIDTH-1:0] buf_read_data,
    output logic                  buf_read_data_valid,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [1:0]            total_q;
    logic [1:0]            issued_q;
    logic [1:0]            returned_q;
    logic [1:0]            discard_q;
    logic                  done_q;

    logic       accept;
    logic       bus_fire;
    logic       drop;
    logic       fwd;
    logic       complete;
    logic [1:0] issued_inc;
    logic [1:0] returned_inc;
    logic [2:0] discard_sum;
    logic [1:0] discard_d;

    // New work only once the previous request's stale returns have drained.
    assign req_ready = (state_q == IDLE) && (discard_q == 2'd0) && !flush;
    assign accept    = req_valid && req_ready;
    assign buf_clear = accept;

    // Address is derived from state, so it holds steady across bus stalls
    // and wraps naturally at ADDR_WIDTH.
    assign bus_read_req = (state_q == ISSUE);
    assign bus_addr     = base_q + ADDR_WIDTH'(issued_q);
    assign bus_fire     = bus_read_req && bus_ready;

    // Stale returns are consumed first; only live requests forward.
    assign drop = bus_read_data_valid && (discard_q != 2'd0);
    assign fwd  = bus_read_data_valid && (discard_q == 2'd0) &&
                  ((state_q == ISSUE) || (state_q == WAIT));

    assign buf_read_data       = bus_read_data;
    assign buf_read_data_valid = fwd;

    assign issued_inc   = issued_q + 2'(bus_fire);
    assign returned_inc = returned_q + 2'(fwd);
    assign complete     = fwd && (returned_inc == total_q);
    assign done         = done_q;

    // In-flight reads left behind by a flush, counting this cycle's issue
    // accept and return; never exceeds 2, so the low bits are exact.
    assign discard_sum = 3'(discard_q) - 3'(drop) + 3'(issued_inc) - 3'(returned_inc);
    assign discard_d   = discard_sum[1:0];

    // Request FSM with issue/return bookkeeping; flush overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            total_q    <= 2'd0;
            issued_q   <= 2'd0;
            returned_q <= 2'd0;
            discard_q  <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q    <= IDLE;
                discard_q  <= discard_d;
                issued_q   <= 2'd0;
                returned_q <= 2'd0;
            end else begin
                if (drop) discard_q <= discard_q - 2'd1;
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            base_q     <= req_addr;
                            total_q    <= 2'(req_len) + 2'd1;
                            issued_q   <= 2'd0;
                            returned_q <= 2'd0;
                            state_q    <= ISSUE;
                        end
                    end
                    ISSUE, WAIT: begin
                        issued_q   <= issued_inc;
                        returned_q <= returned_inc;
                        if (complete) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if ((state_q == ISSUE) && bus_fire &&
                                     (issued_inc == total_q)) begin
                            state_q <= WAIT;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_read_issuer.sv
// Randomized bench for read_issuer. A bus model answers accepted reads in
// order with address-derived data; a reference model tracks requests as
// lists of word addresses and pushes expected words into a scoreboard that
// a separate monitor drains whenever the buffer sees a forwarded word.
module tb_read_issuer;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_len;
    logic          bus_read_req;
    logic [AW-1:0] bus_addr;
    logic          bus_ready;
    logic [DW-1:0] bus_read_data;
    logic          bus_read_data_valid;
    logic          buf_clear;
    logic [DW-1:0] buf_read_data;
    logic          buf_read_data_valid;
    logic          done;

    read_issuer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .flush               (flush),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .bus_read_req        (bus_read_req),
        .bus_addr            (bus_addr),
        .bus_ready           (bus_ready),
        .bus_read_data       (bus_read_data),
        .bus_read_data_valid (bus_read_data_valid),
        .buf_clear           (buf_clear),
        .buf_read_data       (buf_read_data),
        .buf_read_data_valid (buf_read_data_valid),
        .done                (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            id;
    } pend_t;

    int            checks   = 0;
    int            failures = 0;
    pend_t         pend_q[$];   // reads the bus has accepted, not yet returned
    logic [DW-1:0] sb_q[$];     // words the buffer should still receive
    logic [AW-1:0] issue_q[$];  // word addresses still to be issued
    bit            busy     = 1'b0;
    int            cur_id   = 0;
    int            ret_left = 0;
    bit            exp_done = 1'b0;
    bit            run      = 1'b0;
    logic [DW-1:0] mon_w;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {a, 2'b01} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: data of every forwarded word and the done pulse.
    always @(negedge clk) begin
        if (run) begin
            chk("done", 64'(done), 64'(exp_done));
            if (buf_read_data_valid) begin
                if (sb_q.size() == 0) chk("fwd_unexpected", 64'd1, 64'd0);
                else begin
                    mon_w = sb_q.pop_front();
                    chk("fwd_data", 64'(buf_read_data), 64'(mon_w));
                end
            end
        end
    end

    // Reference model: handshake expectations and request bookkeeping.
    always @(negedge clk) begin : model
        bit exp_rdy, acc, ebr, fwd;
        if (run) begin
            #1;
            exp_rdy = !busy && (pend_q.size() == 0) && !flush;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            acc = req_valid && exp_rdy;
            chk("buf_clear", 64'(buf_clear), 64'(acc));
            ebr = busy && (issue_q.size() > 0);
            chk("bus_read_req", 64'(bus_read_req), 64'(ebr));
            if (ebr) chk("bus_addr", 64'(bus_addr), 64'(issue_q[0]));
            fwd = bus_read_data_valid && busy && (pend_q.size() > 0) &&
                  (pend_q[0].id == cur_id);
            chk("fwd_valid", 64'(buf_read_data_valid), 64'(fwd));

            exp_done = 1'b0;
            if (bus_read_data_valid && pend_q.size() > 0) void'(pend_q.pop_front());
            if (bus_read_req && bus_ready) begin
                pend_q.push_back('{bus_addr, cur_id});
                if (issue_q.size() > 0) void'(issue_q.pop_front());
            end
            if (fwd) begin
                ret_left--;
                if (ret_left == 0) begin
                    busy     = 1'b0;
                    exp_done = !flush;
                end
            end
            if (flush) begin
                busy     = 1'b0;
                exp_done = 1'b0;
                sb_q.delete();
                issue_q.delete();
                cur_id++;
            end
            if (acc) begin
                busy     = 1'b1;
                cur_id++;
                ret_left = int'(req_len) + 1;
                issue_q.push_back(req_addr);
                sb_q.push_back(word_of(req_addr));
                if (req_len) begin
                    issue_q.push_back(AW'(req_addr + 1'b1));
                    sb_q.push_back(word_of(AW'(req_addr + 1'b1)));
                end
            end
        end
    end

    // Stimulus: random CPU requests, flushes, bus stalls and in-order returns.
    initial begin
        reset_n             = 1'b0;
        flush               = 1'b0;
        req_valid           = 1'b0;
        req_addr            = '0;
        req_len             = 1'b0;
        bus_ready           = 1'b0;
        bus_read_data_valid = 1'b0;
        bus_read_data       = '0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_bus_read_req", 64'(bus_read_req), 64'd0);
        chk("rst_buf_clear", 64'(buf_clear), 64'd0);
        chk("rst_buf_valid", 64'(buf_read_data_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run     = 1'b1;

        repeat (4000) begin
            @(posedge clk); #1;
            flush     = ($urandom % 14) == 0;
            req_valid = $urandom % 2;
            req_len   = $urandom % 2;
            req_addr  = (($urandom % 4) == 0) ? {AW{1'b1}} : AW'($urandom);
            bus_ready = ($urandom % 3) != 0;
            if (pend_q.size() > 0 && ($urandom % 3) != 0) begin
                bus_read_data_valid = 1'b1;
                bus_read_data       = word_of(pend_q[0].addr);
            end else begin
                bus_read_data_valid = 1'b0;
                bus_read_data       = $urandom;
            end
        end

        // Reset in the middle of an issue: outputs must drop at once.
        @(posedge clk); #1;
        run                 = 1'b0;
        flush               = 1'b0;
        req_valid           = 1'b0;
        bus_ready           = 1'b0;
        bus_read_data_valid = 1'b0;
        reset_n             = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        req_valid = 1'b1;
        req_addr  = AW'(32'h100);
        req_len   = 1'b1;
        #1;
        chk("dir_req_ready", 64'(req_ready), 64'd1);
        chk("dir_buf_clear", 64'(buf_clear), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("dir_bus_read_req", 64'(bus_read_req), 64'd1);
        chk("dir_bus_addr", 64'(bus_addr), 64'h100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_bus_read_req", 64'(bus_read_req), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
